// File: rtl/uart_frame_parser_pkg.sv
// Shared constants and types for the UART command-frame parser:
// default frame parameters, error codes and FSM state encoding.
package uart_frame_parser_pkg;

  localparam logic [7:0]  SOF_DEFAULT     = 8'hAA;
  localparam int unsigned MAX_LEN_DEFAULT = 16;
  localparam int unsigned TIMEOUT_DEFAULT = 8680;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_LEN     = 3'd1,
    ERR_CHK     = 3'd2,
    ERR_TIMEOUT = 3'd3,
    ERR_OVERRUN = 3'd4
  } err_code_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_HOLD
  } state_e;

endpackage

// File: rtl/uart_frame_parser_buf.sv
// Payload buffer: DEPTH x WIDTH register file, one write port and one
// registered read port (1-cycle latency).
module uart_frame_parser_buf #(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage write; contents survive reset.
  // NOTE: the array has no reset so it maps to plain storage; readers never
  // rely on its contents before a frame has written them.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read port.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values and simulation matches the synthesized netlist.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles SOF/CMD/LEN/payload/CHK frames from UART bytes, validates
// length and XOR checksum, and holds the decoded frame until acknowledged.
module uart_frame_parser
  import uart_frame_parser_pkg::*;
#(
  parameter  logic [7:0]  SOF_BYTE       = SOF_DEFAULT,
  parameter  int unsigned MAX_LEN        = MAX_LEN_DEFAULT,
  parameter  int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  localparam int unsigned LEN_W          = $clog2(MAX_LEN + 1),
  localparam int unsigned ADDR_W         = $clog2(MAX_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic              rx_arm,
  output logic              frame_valid,
  output logic [7:0]        frame_cmd,
  output logic [LEN_W-1:0]  frame_len,
  input  logic              frame_ack,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              err,
  output logic [2:0]        err_code
);

  localparam int unsigned    CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic              done_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        chk_q, chk_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              err_q, err_d;
  err_code_e         err_code_q, err_code_d;

  logic byte_stb;
  logic in_frame;
  logic timeout;
  logic buf_we;

  assign byte_stb = rx_done & ~done_q;
  assign in_frame = (state_q == ST_CMD) || (state_q == ST_LEN) ||
                    (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
  // A strobe in the same cycle restarts the count instead of timing out.
  assign timeout  = in_frame && !byte_stb && (cnt_q == TO_LAST);

  // State, datapath and error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      chk_q      <= '0;
      cmd_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      done_q     <= rx_done;
      cnt_q      <= cnt_d;
      chk_q      <= chk_d;
      cmd_q      <= cmd_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // Next-state logic: frame sequencing, checksum, timeout and error reporting.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = (byte_stb || !in_frame) ? '0 : cnt_q + CNT_W'(1);
    chk_d      = chk_q;
    cmd_d      = cmd_q;
    len_d      = len_q;
    idx_d      = idx_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    buf_we     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (byte_stb && rx_data == SOF_BYTE) state_d = ST_CMD;
      end
      ST_CMD: begin
        if (byte_stb) begin
          cmd_d   = rx_data;
          chk_d   = rx_data;
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (byte_stb) begin
          if (32'(rx_data) > MAX_LEN) begin
            err_d      = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = ST_IDLE;
          end else begin
            len_d   = rx_data[LEN_W-1:0];
            chk_d   = chk_q ^ rx_data;
            idx_d   = '0;
            state_d = (rx_data == 8'd0) ? ST_CHK : ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (byte_stb) begin
          buf_we = 1'b1;
          chk_d  = chk_q ^ rx_data;
          idx_d  = idx_q + ADDR_W'(1);
          if (LEN_W'(idx_q) == len_q - LEN_W'(1)) state_d = ST_CHK;
        end
      end
      ST_CHK: begin
        if (byte_stb) begin
          if (rx_data == chk_q) begin
            state_d = ST_HOLD;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_CHK;
            state_d    = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        // A byte arriving while a frame is held is lost, even if the ack
        // lands in the same cycle.
        if (byte_stb) begin
          err_d      = 1'b1;
          err_code_d = ERR_OVERRUN;
        end
        if (frame_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (timeout) begin
      err_d      = 1'b1;
      err_code_d = ERR_TIMEOUT;
      state_d    = ST_IDLE;
    end
  end

  uart_frame_parser_buf #(
    .DEPTH (MAX_LEN),
    .WIDTH (8)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .we_i    (buf_we),
    .waddr_i (idx_q),
    .wdata_i (rx_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign rx_arm      = (state_q != ST_HOLD);
  assign frame_valid = (state_q == ST_HOLD);
  assign frame_cmd   = cmd_q;
  assign frame_len   = len_q;
  assign err         = err_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: directed frame scenarios plus
// randomized frames judged against a frame-level reference model.
module tb_uart_frame_parser;

  localparam int MAX_LEN = 16;
  localparam int TIMEOUT = 8680;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_arm;
  logic       frame_valid;
  logic [7:0] frame_cmd;
  logic [4:0] frame_len;
  logic       frame_ack;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       err;
  logic [2:0] err_code;

  int total = 0;
  int bad   = 0;

  // Byte stream to send and the expected outcome of the frame it carries:
  // exp_kind 0 = valid frame, otherwise the error code expected.
  logic [7:0] tx_q[$];
  logic [7:0] exp_pl[$];
  int         exp_kind;
  logic [7:0] exp_cmd;
  int         exp_len;
  int         err_log[$];

  uart_frame_parser dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .rx_arm      (rx_arm),
    .frame_valid (frame_valid),
    .frame_cmd   (frame_cmd),
    .frame_len   (frame_len),
    .frame_ack   (frame_ack),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .err         (err),
    .err_code    (err_code)
  );

  always #10 clk = ~clk;

  // Every err pulse is logged once, sampled mid-cycle.
  always @(negedge clk) if (err === 1'b1) err_log.push_back(int'(err_code));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One byte with a single-cycle rx_done; returns just after the strobe edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick(1);
    rx_done = 1'b0;
  endtask

  task automatic send_all();
    foreach (tx_q[i]) begin
      tick($urandom_range(1, 4));
      send_byte(tx_q[i]);
    end
  endtask

  task automatic check_errs(input string tag, input int code);
    check({tag, "_errcnt"}, 32'(err_log.size()), (code == 0) ? 32'd0 : 32'd1);
    if (err_log.size() > 0) check({tag, "_errcode"}, 32'(err_log[0]), 32'(code));
    err_log.delete();
  endtask

  // Reference model: frame outcome follows from the bytes as constructed.
  task automatic build_frame(input logic [7:0] cmd, input int len, input bit corrupt,
                             input int njunk);
    logic [7:0] chk;
    logic [7:0] b;
    tx_q.delete();
    exp_pl.delete();
    for (int j = 0; j < njunk; j++) begin
      do b = 8'($urandom); while (b == 8'hAA);
      tx_q.push_back(b);
    end
    tx_q.push_back(8'hAA);
    tx_q.push_back(cmd);
    tx_q.push_back(8'(len));
    exp_cmd = cmd;
    exp_len = len;
    if (len > MAX_LEN) begin
      exp_kind = 1;
      return;
    end
    chk = cmd ^ 8'(len);
    for (int j = 0; j < len; j++) begin
      b = ($urandom_range(0, 5) == 0) ? 8'hAA : 8'($urandom);
      exp_pl.push_back(b);
      tx_q.push_back(b);
      chk = chk ^ b;
    end
    if (corrupt) begin
      tx_q.push_back(chk ^ 8'($urandom_range(1, 255)));
      exp_kind = 2;
    end else begin
      tx_q.push_back(chk);
      exp_kind = 0;
    end
  endtask

  task automatic check_held(input string tag);
    check({tag, "_valid"}, 32'(frame_valid), 32'd1);
    check({tag, "_arm"},   32'(rx_arm),      32'd0);
    check({tag, "_cmd"},   32'(frame_cmd),   32'(exp_cmd));
    check({tag, "_len"},   32'(frame_len),   32'(exp_len));
    for (int i = 0; i < exp_len; i++) begin
      rd_addr = 4'(i);
      tick(1);
      check({tag, "_rd"}, 32'(rd_data), 32'(exp_pl[i]));
    end
  endtask

  task automatic do_ack(input string tag);
    frame_ack = 1'b1;
    tick(1);
    frame_ack = 1'b0;
    check({tag, "_ackvalid"}, 32'(frame_valid), 32'd0);
    check({tag, "_ackarm"},   32'(rx_arm),      32'd1);
  endtask

  // Judge the frame just sent against the model's expectation.
  task automatic check_outcome(input string tag, input bit ack);
    tick(1);
    if (exp_kind == 0) begin
      check_held(tag);
      check_errs(tag, 0);
      if (ack) do_ack(tag);
    end else begin
      check({tag, "_valid"},   32'(frame_valid), 32'd0);
      check({tag, "_err"},     32'(err),         32'd0);
      check({tag, "_errcode"}, 32'(err_code),    32'(exp_kind));
      check_errs(tag, exp_kind);
    end
  endtask

  initial begin
    int k;
    rst       = 1'b1;
    rx_data   = '0;
    rx_done   = 1'b0;
    frame_ack = 1'b0;
    rd_addr   = '0;
    tick(3);
    rst = 1'b0;
    tick(1);

    // Reset state
    check("rst_valid",   32'(frame_valid), 32'd0);
    check("rst_arm",     32'(rx_arm),      32'd1);
    check("rst_err",     32'(err),         32'd0);
    check("rst_errcode", 32'(err_code),    32'd0);
    check("rst_cmd",     32'(frame_cmd),   32'd0);
    check("rst_len",     32'(frame_len),   32'd0);
    check("rst_rd",      32'(rd_data),     32'd0);

    // T1: basic two-byte payload frame
    tx_q = '{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
    exp_kind = 0; exp_cmd = 8'h01; exp_len = 2; exp_pl = '{8'h10, 8'h20};
    send_all();
    check_outcome("t1", 1'b1);

    // T2: zero-length frame, then junk before SOF
    tx_q = '{8'hAA, 8'h05, 8'h00, 8'h05};
    exp_kind = 0; exp_cmd = 8'h05; exp_len = 0; exp_pl.delete();
    send_all();
    check_outcome("t2a", 1'b1);
    tx_q = '{8'h55, 8'hAA, 8'h07, 8'h00, 8'h07};
    exp_cmd = 8'h07;
    send_all();
    check_outcome("t2b", 1'b1);

    // T3: bad checksum, then oversize length
    tx_q = '{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h34};
    exp_kind = 2;
    send_all();
    check_outcome("t3chk", 1'b0);
    tx_q = '{8'hAA, 8'h01, 8'h11};
    exp_kind = 1;
    send_all();
    check_outcome("t3len", 1'b0);

    // T4: inter-byte timeout fires exactly TIMEOUT cycles after the last byte
    tx_q = '{8'hAA, 8'h01, 8'h02, 8'h10};
    send_all();
    k = 0;
    while (k < TIMEOUT + 50 && err !== 1'b1) begin
      tick(1);
      k++;
    end
    check("t4_delay",   32'(k),        32'(TIMEOUT));
    check("t4_errcode", 32'(err_code), 32'd3);
    tick(1);
    check("t4_valid", 32'(frame_valid), 32'd0);
    check_errs("t4", 3);
    // A byte one cycle before the limit keeps the frame alive
    tx_q = '{8'hAA, 8'h01, 8'h02, 8'h10};
    send_all();
    tick(TIMEOUT - 2);
    send_byte(8'h20);
    tick(2);
    send_byte(8'h33);
    exp_kind = 0; exp_cmd = 8'h01; exp_len = 2; exp_pl = '{8'h10, 8'h20};
    check_outcome("t4b", 1'b0);

    // T5: overrun while held, then byte coincident with ack
    tick(2);
    send_byte(8'h5A);
    tick(1);
    check_errs("t5", 4);
    check_held("t5held");
    rx_data   = 8'h66;
    rx_done   = 1'b1;
    frame_ack = 1'b1;
    tick(1);
    rx_done   = 1'b0;
    frame_ack = 1'b0;
    check("t5b_valid",   32'(frame_valid), 32'd0);
    check("t5b_err",     32'(err),         32'd1);
    check("t5b_errcode", 32'(err_code),    32'd4);
    tick(1);
    check_errs("t5b", 4);

    // T6: long rx_done level yields a single byte
    rx_data = 8'hAA;
    rx_done = 1'b1;
    tick(400);
    rx_done = 1'b0;
    tx_q = '{8'h01, 8'h00, 8'h01};
    exp_kind = 0; exp_cmd = 8'h01; exp_len = 0; exp_pl.delete();
    send_all();
    check_outcome("t6", 1'b1);

    // Async reset mid-payload, after err_code has been left non-zero
    tx_q = '{8'hAA, 8'h03, 8'h04, 8'h11, 8'h22};
    send_all();
    #3 rst = 1'b1;
    #1;
    check("t6r_valid",   32'(frame_valid), 32'd0);
    check("t6r_arm",     32'(rx_arm),      32'd1);
    check("t6r_err",     32'(err),         32'd0);
    check("t6r_errcode", 32'(err_code),    32'd0);
    check("t6r_cmd",     32'(frame_cmd),   32'd0);
    check("t6r_len",     32'(frame_len),   32'd0);
    check("t6r_rd",      32'(rd_data),     32'd0);
    tick(2);
    rst = 1'b0;
    tick(1);
    err_log.delete();
    build_frame(8'h3C, 4, 1'b0, 0);
    send_all();
    check_outcome("t6post", 1'b1);

    // Randomized frames: good, corrupt checksum, oversize length, junk prefix
    for (int n = 0; n < 24; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 15) build_frame(8'($urandom), $urandom_range(MAX_LEN + 1, 255), 1'b0,
                              $urandom_range(0, 2));
      else        build_frame(8'($urandom), $urandom_range(0, MAX_LEN), r < 30,
                              $urandom_range(0, 2));
      send_all();
      check_outcome("rnd", 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
